fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// - Drives the program counter's incr level and fetches the word at the current PC from program ROM.
// - Presents each fetched word downstream with a valid/ready handshake.
// - Sits between the PC (edge-triggered incr, async reset) and the decode stage.
// - Supports free-run, single-step and halt-on-HALT_WORD.
// PARAMETERS
// - ADDR_W   8       PC/ROM address width
// - DATA_W   16      instruction width
// - MEM_LAT  1       ROM read latency in clocks, >=1
// - HALT_WORD 16'hFFFF  opcode that stops the sequencer; width DATA_W
// PORTS
// - clk          in   1       clock, all state on rising edge
// - reset        in   1       asynchronous, active-high
// - run          in   1       level; 1 = fetch continuously
// - step         in   1       1-cycle pulse; fetch exactly one word when idle
// - pc_in        in   ADDR_W  current PC value
// - incr_out     out  1       level to PC incr; PC advances on its 0->1 edge
// - rom_addr     out  ADDR_W  ROM address
// - rom_data     in   DATA_W  ROM data, valid MEM_LAT clocks after rom_addr
// - instr        out  DATA_W  fetched word
// - instr_valid  out  1       instr valid
// - instr_ready  in   1       downstream accepts when valid&ready
// - busy         out  1       1 in any state except IDLE/HALTED
// - halted       out  1       HALT_WORD fetched
// - bp_addr      in   ADDR_W  breakpoint address; used only with SEQ_BREAKPOINT_EN
// - bp_hit       out  1       breakpoint stop flag
// BEHAVIOUR
// - Reset (any time, including mid-fetch):
//   - state=IDLE; incr_out=0, instr_valid=0, instr=0, busy=0, halted=0, bp_hit=0.
//   - rom_addr=pc_in; it tracks pc_in combinationally in all states.
// - States: IDLE, FETCH, HOLD, ADVANCE, SETTLE, HALTED.
// - IDLE:
//   - run=1 -> FETCH.
//   - step=1 with run=0 -> FETCH, one-shot.
//   - run and step both high -> run wins; step ignored.
// - FETCH:
//   - Wait counter 0..MEM_LAT-1; on terminal count, capture rom_data into instr.
//   - Captured word == HALT_WORD -> HALTED. It is not presented and incr is not raised.
//   - Otherwise -> HOLD.
// - HOLD: instr_valid=1, instr stable. On the valid&ready edge -> ADVANCE; instr_valid drops the next cycle.
// - ADVANCE: incr_out=1 for exactly one clock; the PC samples the 0->1 edge and updates at this edge.
// - SETTLE:
//   - incr_out=0 for one clock so the PC sees a low before the next edge; pc_in is now PC+1.
//   - If run=1 -> FETCH; else -> IDLE. A one-shot step always ends in IDLE.
// - Latency, MEM_LAT=1, ready tied 1:
//   - IDLE exit to first instr_valid = 2 clocks.
//   - 4 clocks per instruction in free-run: FETCH, HOLD, ADVANCE, SETTLE.
// - incr_out is never high on two consecutive clocks.
// - incr_out is 0 in every state except ADVANCE.
// - Deasserting run mid-sequence finishes the current instruction (through SETTLE), then IDLE.
// - HALTED: halted=1, busy=0; run and step are ignored. Exit only by reset.
// - PC wrap (pc_in 2^ADDR_W-1 -> 0) needs no special handling; fetch continues from 0.
// - step pulses arriving while busy are dropped, not queued.
// CONFIGURATION
// - SEQ_BREAKPOINT_EN defined:
//   - Entering FETCH from IDLE or SETTLE with pc_in==bp_addr -> go to IDLE instead and set bp_hit=1.
//   - bp_hit clears on the next step or run rising edge.
//   - The next step or run from a breakpoint fetches bp_addr normally; the same address does not re-trigger on that fetch.
// - SEQ_BREAKPOINT_EN undefined: bp_addr is ignored, bp_hit is tied 0, and no compare logic is built.
// TESTING
// 1. ROM[0..3]=1111,2222,3333,FFFF; run=1, ready=1 -> instr 1111,2222,3333 presented once each; incr_out 3 single-cycle pulses; then halted=1, pc_in=3.
// 2. step pulse with pc_in=5, ROM[5]=ABCD -> one instr_valid with ABCD, one incr pulse, pc_in=6, back in IDLE, busy=0.
// 3. run=1, ready held 0 for 5 clocks -> instr_valid=1 and instr stable for 5 clocks, incr_out=0; ready=1 -> ADVANCE next clock.
// 4. Assert reset during HOLD at pc_in=7 -> all outputs 0 immediately; no incr pulse; after release with run=0, stays IDLE.
// 5. pc_in=FF, ROM[FF]=0001, ROM[00]=0002, run=1 -> 0001 then 0002; PC wraps to 00 cleanly; exactly one incr edge per word.
// 6. SEQ_BREAKPOINT_EN, bp_addr=02, run=1 from 0 -> words 0,1 issued, bp_hit=1 at pc=2, IDLE; step -> ROM[2] fetched, bp_hit=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: PC, ROM and instruction-handoff signals of the fetch sequencer.
// Latency: none, wires only.
// Backpressure: instr_valid/instr_ready handshake travels on this bundle.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pc_in;
  logic              incr_out;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;

  // Sequencer side
  modport master (
    input  pc_in, rom_data, instr_ready,
    output incr_out, rom_addr, instr, instr_valid
  );

  // PC / ROM / decode side
  modport slave (
    output pc_in, rom_data, instr_ready,
    input  incr_out, rom_addr, instr, instr_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: steps the PC through program ROM and hands each word to decode.
// Latency: MEM_LAT+1 clocks from IDLE exit to instr_valid; free-run costs MEM_LAT+3 clocks per word.
// Backpressure: instr/instr_valid held until instr_ready; step pulses while busy are dropped.
// Optional breakpoint stop is built only when SEQ_BREAKPOINT_EN is defined.
module fetch_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 16,
  parameter int                MEM_LAT   = 1,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(16'hFFFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              busy,
  output logic              halted,
  output logic              bp_hit,
  fetch_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_SETTLE  = 3'd4;
  localparam logic [2:0] S_HALTED  = 3'd5;

  localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              oneshot_q, oneshot_d;
  logic              start_run, start_step, fetch_req;

`ifdef SEQ_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic run_prev_q, run_prev_d;
`endif

  // Next-state: sequencing through fetch, handoff, PC pulse and settle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    instr_d    = instr_q;
    oneshot_d  = oneshot_q;
    fetch_req  = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bp_hit_d   = bp_hit_q;
    run_prev_d = run;
    // While parked on a breakpoint a held-high run must not restart by level.
    start_run  = bp_hit_q ? (run & ~run_prev_q) : run;
`else
    start_run  = run;
`endif
    // run has priority over a simultaneous step.
    start_step = step & ~start_run;

    case (state_q)
      S_IDLE: begin
        if (start_run) begin
          fetch_req = 1'b1;
          oneshot_d = 1'b0;
        end else if (start_step) begin
          fetch_req = 1'b1;
          oneshot_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (wait_cnt_q == LAST_CNT) begin
          instr_d = bus.rom_data;
          state_d = (bus.rom_data == HALT_WORD) ? S_HALTED : S_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) state_d = S_ADVANCE;
      end
      S_ADVANCE: state_d = S_SETTLE;
      S_SETTLE: begin
        if (run && !oneshot_q) fetch_req = 1'b1;
        else                   state_d   = S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    if (fetch_req) begin
`ifdef SEQ_BREAKPOINT_EN
      // A start from IDLE consumes the stop flag and is allowed past the breakpoint once.
      if (state_q == S_IDLE) bp_hit_d = 1'b0;
      if ((bus.pc_in == bp_addr) && !((state_q == S_IDLE) && bp_hit_q)) begin
        state_d  = S_IDLE;
        bp_hit_d = 1'b1;
      end else begin
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end
`else
      state_d    = S_FETCH;
      wait_cnt_d = '0;
`endif
    end
  end

  // State and datapath registers; reset parks the sequencer in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      instr_q    <= '0;
      oneshot_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      instr_q    <= instr_d;
      oneshot_q  <= oneshot_d;
    end
  end

`ifdef SEQ_BREAKPOINT_EN
  // Breakpoint flag and run history for rising-edge restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_hit_q   <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      bp_hit_q   <= bp_hit_d;
      run_prev_q <= run_prev_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^bp_addr;
  assign bp_hit    = 1'b0;
`endif

  assign bus.rom_addr    = bus.pc_in;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == S_HOLD);
  assign bus.incr_out    = (state_q == S_ADVANCE);
  assign busy            = (state_q == S_FETCH) || (state_q == S_HOLD) ||
                           (state_q == S_ADVANCE) || (state_q == S_SETTLE);
  assign halted          = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table, hand-written corner cases and randomized runs
// against a program-walk model (ROM words from start PC until HALT_WORD).
module tb_fetch_sequencer;
  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       run     = 1'b0;
  logic       step    = 1'b0;
  logic [7:0] bp_addr = 8'h00;
  logic       busy, halted, bp_hit;

  fetch_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  fetch_sequencer #(
    .ADDR_W(8), .DATA_W(16), .MEM_LAT(1), .HALT_WORD(16'hFFFF)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .bp_addr(bp_addr),
    .busy(busy), .halted(halted), .bp_hit(bp_hit), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // PC: advances on a 0->1 edge of incr, loadable by the bench.
  logic [7:0] pc          = 8'h00;
  logic       incr_seen   = 1'b0;
  logic       pc_load     = 1'b0;
  logic [7:0] pc_load_val = 8'h00;
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (bus.incr_out && !incr_seen) pc <= pc + 8'd1;
    incr_seen <= bus.incr_out;
  end
  assign bus.pc_in = pc;

  // Synchronous ROM, one clock of latency.
  logic [15:0] rom [256];
  logic [15:0] rom_q = 16'h0000;
  always @(posedge clk) rom_q <= rom[bus.rom_addr];
  assign bus.rom_data = rom_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records accepted words and counts protocol violations.
  logic [15:0] got_q[$];
  int          acc_cyc[$];
  int          incr_cnt = 0;
  int          viol = 0;
  logic        p_incr = 1'b0, p_vld = 1'b0, p_rdy = 1'b0;
  logic [15:0] p_instr = 16'h0000;
  always @(negedge clk) begin
    if (bus.instr_valid && bus.instr_ready) begin
      got_q.push_back(bus.instr);
      acc_cyc.push_back(cyc);
    end
    if (bus.incr_out && !p_incr) incr_cnt++;
    if (bus.incr_out && p_incr) viol++;
    if (bus.instr_valid && p_vld && !p_rdy && bus.instr !== p_instr) viol++;
    if (bus.instr_valid && p_vld && p_rdy) viol++;
    if (bus.incr_out && bus.instr_valid) viol++;
    if (halted && busy) viol++;
    if (bus.rom_addr !== bus.pc_in) viol++;
`ifndef SEQ_BREAKPOINT_EN
    if (bp_hit) viol++;
`endif
    p_incr  = bus.incr_out;
    p_vld   = bus.instr_valid;
    p_rdy   = bus.instr_ready;
    p_instr = bus.instr;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_at(input logic [7:0] p);
    do_reset();
    bp_addr     = p - 8'd1;
    pc_load_val = p;
    pc_load     = 1'b1;
    @(posedge clk); #1;
    pc_load = 1'b0;
    got_q.delete();
    acc_cyc.delete();
    incr_cnt = 0;
    viol     = 0;
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      ok = halted;
    end
  endtask

  typedef struct {
    logic [7:0]       pc0;
    logic [3:0][15:0] w;        // w[0] sits at pc0
    bit               use_step;
    int               exp_n;
    logic [7:0]       exp_pc;
    bit               exp_halt;
  } vec_t;

  vec_t vt[6];

  initial begin
    bit          ok;
    int          bad;
    int          c0;
    int          len;
    logic [7:0]  p0;
    logic [15:0] exp_w[$];

    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    bus.instr_ready = 1'b1;

    // Outputs while reset is held from time zero.
    #1;
    check("reset_outputs", {11'd0, bus.incr_out, bus.instr_valid, bus.instr, busy, halted, bp_hit}, 32'd0);
    check("reset_rom_addr", bus.rom_addr, pc);

    vt[0] = '{pc0: 8'h00, w: {16'hFFFF, 16'h3333, 16'h2222, 16'h1111}, use_step: 1'b0, exp_n: 3, exp_pc: 8'h03, exp_halt: 1'b1};
    vt[1] = '{pc0: 8'h05, w: {16'h0000, 16'h0000, 16'hFFFF, 16'hABCD}, use_step: 1'b1, exp_n: 1, exp_pc: 8'h06, exp_halt: 1'b0};
    vt[2] = '{pc0: 8'hFF, w: {16'h0000, 16'hFFFF, 16'h0002, 16'h0001}, use_step: 1'b0, exp_n: 2, exp_pc: 8'h01, exp_halt: 1'b1};
    vt[3] = '{pc0: 8'h20, w: {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, use_step: 1'b1, exp_n: 0, exp_pc: 8'h20, exp_halt: 1'b1};
    vt[4] = '{pc0: 8'h30, w: {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, use_step: 1'b0, exp_n: 0, exp_pc: 8'h30, exp_halt: 1'b1};
    vt[5] = '{pc0: 8'h80, w: {16'h0000, 16'h0000, 16'hFFFF, 16'h1234}, use_step: 1'b1, exp_n: 1, exp_pc: 8'h81, exp_halt: 1'b0};

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) rom[8'(vt[n].pc0 + 8'(i))] = vt[n].w[i];
      bus.instr_ready = 1'b1;
      start_at(vt[n].pc0);
      c0 = cyc;
      if (vt[n].use_step) begin
        step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
      end else begin
        run = 1'b1;
      end
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
        @(negedge clk);
        ok = vt[n].use_step ? !busy : halted;
      end
      check($sformatf("vec%0d_done", n), ok, 1);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_nwords", n), got_q.size(), vt[n].exp_n);
      for (int i = 0; i < vt[n].exp_n && i < got_q.size(); i++)
        check($sformatf("vec%0d_word%0d", n, i), got_q[i], vt[n].w[i]);
      check($sformatf("vec%0d_pc", n), pc, vt[n].exp_pc);
      check($sformatf("vec%0d_halted", n), halted, vt[n].exp_halt);
      check($sformatf("vec%0d_busy", n), busy, 0);
      check($sformatf("vec%0d_incr_pulses", n), incr_cnt, vt[n].exp_n);
      check($sformatf("vec%0d_protocol", n), viol, 0);
      if (vt[n].exp_n >= 1 && acc_cyc.size() >= 1)
        check($sformatf("vec%0d_first_latency", n), acc_cyc[0] - c0, 2);
      if (vt[n].exp_n >= 2 && acc_cyc.size() >= 2)
        check($sformatf("vec%0d_period", n), acc_cyc[1] - acc_cyc[0], 4);
      run = 1'b0;
    end

    // Stall: ready low keeps the word presented and the PC untouched.
    rom[8'h40] = 16'h5555; rom[8'h41] = 16'h6666; rom[8'h42] = 16'hFFFF;
    bus.instr_ready = 1'b0;
    start_at(8'h40);
    run = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.instr_valid;
    end
    check("stall_reach_hold", ok, 1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (!bus.instr_valid || bus.instr !== 16'h5555 || bus.incr_out) bad++;
    end
    check("stall_hold_stable", bad, 0);
    @(posedge clk); #1 bus.instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_advance_incr", bus.incr_out, 1);
    check("stall_valid_drop", bus.instr_valid, 0);
    wait_halted(100, ok);
    check("stall_halted", ok, 1);
    check("stall_nwords", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("stall_word0", got_q[0], 16'h5555);
      check("stall_word1", got_q[1], 16'h6666);
    end
    check("stall_pc", pc, 8'h42);
    check("stall_protocol", viol, 0);

    // Reset in the middle of HOLD.
    rom[8'h07] = 16'h7777; rom[8'h08] = 16'hFFFF;
    bus.instr_ready = 1'b0;
    start_at(8'h07);
    run = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.instr_valid;
    end
    check("midrst_reach_hold", ok, 1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("midrst_outputs", {11'd0, bus.incr_out, bus.instr_valid, bus.instr, busy, halted, bp_hit}, 32'd0);
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_idle_busy", busy, 0);
    check("midrst_no_incr", incr_cnt, 0);
    check("midrst_no_words", got_q.size(), 0);
    check("midrst_pc", pc, 8'h07);
    check("midrst_protocol", viol, 0);

`ifdef SEQ_BREAKPOINT_EN
    // Breakpoint stop and single-step resume past it.
    rom[8'h00] = 16'h1111; rom[8'h01] = 16'h2222; rom[8'h02] = 16'h3333; rom[8'h03] = 16'hFFFF;
    bus.instr_ready = 1'b1;
    start_at(8'h00);
    bp_addr = 8'h02;
    run = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      ok = bp_hit;
    end
    check("bp_stop", ok, 1);
    @(posedge clk); #1 run = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_nwords", got_q.size(), 2);
    check("bp_pc", pc, 8'h02);
    check("bp_busy", busy, 0);
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      ok = !busy;
    end
    check("bp_step_done", ok, 1);
    check("bp_cleared", bp_hit, 0);
    check("bp_step_nwords", got_q.size(), 3);
    if (got_q.size() == 3) check("bp_step_word", got_q[2], 16'h3333);
    check("bp_step_pc", pc, 8'h03);
`endif

    // Randomized programs with random ready, run and step activity.
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(1, 8);
      p0  = 8'($urandom_range(0, 255));
      exp_w.delete();
      for (int i = 0; i < len; i++) begin
        exp_w.push_back(16'($urandom_range(0, 16'hFFFE)));
        rom[8'(p0 + 8'(i))] = exp_w[i];
      end
      rom[8'(p0 + 8'(len))] = 16'hFFFF;
      bus.instr_ready = 1'b1;
      start_at(p0);
      ok = 1'b0;
      for (int k = 0; k < 600 && !ok; k++) begin
        @(posedge clk); #1;
        if (halted) ok = 1'b1;
        else begin
          bus.instr_ready = ($urandom_range(0, 1) == 1);
          run             = ($urandom_range(0, 9) < 7);
          step            = ($urandom_range(0, 9) == 0);
        end
      end
      run = 1'b0; step = 1'b0; bus.instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_halted", it), ok, 1);
      check($sformatf("rnd%0d_nwords", it), got_q.size(), len);
      for (int i = 0; i < len && i < got_q.size(); i++)
        check($sformatf("rnd%0d_word%0d", it, i), got_q[i], exp_w[i]);
      check($sformatf("rnd%0d_pc", it), pc, 8'(p0 + 8'(len)));
      check($sformatf("rnd%0d_incr_pulses", it), incr_cnt, len);
      check($sformatf("rnd%0d_protocol", it), viol, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
